// File: rtl/change_dispenser_if.sv
// ============================================================
// change_dispenser_if: change request in, per-item payout handshake and status out
// Rev 1.0
// ============================================================
`default_nettype none

interface change_dispenser_if;
  logic [11:0] change_in;
  logic        change_valid;
  logic        eject_ack;
  logic        clear_fault;
  logic        eject_req;
  logic [1:0]  eject_denom;
  logic        busy;
  logic [9:0]  remaining;
  logic [7:0]  coin_count;
  logic        done;
  logic        fault;
  logic        bcd_err;

  // master: transaction block / payout mechanism side
  modport master (
    output change_in, change_valid, eject_ack, clear_fault,
    input  eject_req, eject_denom, busy, remaining, coin_count, done, fault, bcd_err
  );

  modport slave (
    input  change_in, change_valid, eject_ack, clear_fault,
    output eject_req, eject_denom, busy, remaining, coin_count, done, fault, bcd_err
  );
endinterface

`default_nettype wire

// File: rtl/change_dispenser.sv
// ============================================================
// change_dispenser: pays a BCD change amount out greedily, one item per req/ack
// Rev 1.0
// ============================================================
`default_nettype none

module change_dispenser #(
  parameter int ACK_TIMEOUT = 1000,
  parameter int GAP_CYCLES  = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  change_dispenser_if.slave  if_bus
);

  localparam int c_TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int c_GAP_W = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES + 1)  : 1;
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SELECT = 3'd2,
    S_EJECT  = 3'd3,
    S_GAP    = 3'd4,
    S_DONE   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t               r_state;
  logic                 r_eject_req;
  logic [1:0]           r_eject_denom;
  logic                 r_busy;
  logic [9:0]           r_remaining;
  logic [7:0]           r_coin_count;
  logic                 r_done;
  logic                 r_fault;
  logic                 r_bcd_err;
  logic [c_TMO_W-1:0]   r_tmo;
  logic [c_GAP_W-1:0]   r_gap;

  logic                 w_bcd_bad;
  logic [9:0]           w_bin;
  logic [1:0]           w_sel;
  logic [9:0]           w_denom_val;

  assign w_bcd_bad = (if_bus.change_in[11:8] > 4'd9) ||
                     (if_bus.change_in[7:4]  > 4'd9) ||
                     (if_bus.change_in[3:0]  > 4'd9);

  assign w_bin = (10'(if_bus.change_in[11:8]) * 10'd100) +
                 (10'(if_bus.change_in[7:4])  * 10'd10)  +
                  10'(if_bus.change_in[3:0]);

  // Greedy pick: largest denomination not exceeding what is still owed
  always_comb begin
    w_sel = 2'b00;
    if (r_remaining >= 10'd20)
      w_sel = 2'b11;
    else if (r_remaining >= 10'd10)
      w_sel = 2'b10;
    else if (r_remaining >= 10'd5)
      w_sel = 2'b01;
  end

  always_comb begin
    w_denom_val = 10'd1;
    case (r_eject_denom)
      2'b00:   w_denom_val = 10'd1;
      2'b01:   w_denom_val = 10'd5;
      2'b10:   w_denom_val = 10'd10;
      default: w_denom_val = 10'd20;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_eject_req   <= 1'b0;
      r_eject_denom <= 2'b00;
      r_busy        <= 1'b0;
      r_remaining   <= 10'd0;
      r_coin_count  <= 8'd0;
      r_done        <= 1'b0;
      r_fault       <= 1'b0;
      r_bcd_err     <= 1'b0;
      r_tmo         <= '0;
      r_gap         <= '0;
    end else begin
      r_done    <= 1'b0;
      r_bcd_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (if_bus.change_valid) begin
            if (w_bcd_bad) begin
              r_bcd_err <= 1'b1;
            end else begin
              r_remaining  <= w_bin;
              r_coin_count <= 8'd0;
              r_busy       <= 1'b1;
              r_state      <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          r_state <= (r_remaining == 10'd0) ? S_DONE : S_SELECT;
        end
        S_SELECT: begin
          r_eject_denom <= w_sel;
          r_eject_req   <= 1'b1;
          r_tmo         <= '0;
          r_state       <= S_EJECT;
        end
        S_EJECT: begin
          // An ack in the same cycle the timer expires still counts as delivered
          if (if_bus.eject_ack) begin
            r_eject_req <= 1'b0;
            r_remaining <= r_remaining - w_denom_val;
            if (r_coin_count != 8'hFF)
              r_coin_count <= r_coin_count + 8'd1;
            r_gap       <= '0;
            r_state     <= S_GAP;
          end else if (r_tmo == c_TMO_LAST) begin
            r_eject_req <= 1'b0;
            r_fault     <= 1'b1;
            r_state     <= S_FAULT;
          end else begin
            r_tmo <= r_tmo + c_TMO_W'(1);
          end
        end
        S_GAP: begin
          if (r_gap == c_GAP_LAST)
            r_state <= (r_remaining == 10'd0) ? S_DONE : S_SELECT;
          else
            r_gap <= r_gap + c_GAP_W'(1);
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_FAULT: begin
          if (if_bus.clear_fault) begin
            r_remaining <= 10'd0;
            r_fault     <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_eject_req <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign if_bus.eject_req   = r_eject_req;
  assign if_bus.eject_denom = r_eject_denom;
  assign if_bus.busy        = r_busy;
  assign if_bus.remaining   = r_remaining;
  assign if_bus.coin_count  = r_coin_count;
  assign if_bus.done        = r_done;
  assign if_bus.fault       = r_fault;
  assign if_bus.bcd_err     = r_bcd_err;

endmodule

`default_nettype wire

// File: tb/tb_change_dispenser.sv
// ============================================================
// tb_change_dispenser: directed vectors for change_dispenser, ACK_TIMEOUT=8, GAP_CYCLES=4
// Rev 1.0
// ============================================================
`default_nettype none

module tb_change_dispenser;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  change_dispenser_if u_if();

  change_dispenser #(
    .ACK_TIMEOUT (8),
    .GAP_CYCLES  (4)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .if_bus (u_if)
  );

  int n_cmp = 0;
  int n_err = 0;
  int q_d[$];
  int q_r[$];
  int e_d[$];
  int e_r[$];
  int n_done;
  int first_req;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Strobe an amount, ack every req on its second high cycle, log denoms and remaining
  task automatic payout(input logic [11:0] amt, input bit extra_strobe);
    int hi;
    bit acked;
    bit seen_done;
    hi        = 0;
    acked     = 1'b0;
    seen_done = 1'b0;
    n_done    = 0;
    first_req = -1;
    q_d.delete();
    q_r.delete();
    @(negedge clk);
    u_if.change_in    = amt;
    u_if.change_valid = 1'b1;
    @(negedge clk);
    u_if.change_valid = 1'b0;
    for (int c = 0; c < 300 && !seen_done; c++) begin
      @(negedge clk);
      if (acked) begin
        u_if.eject_ack = 1'b0;
        acked = 1'b0;
        q_r.push_back(int'(u_if.remaining));
      end
      if (u_if.eject_req) begin
        if (first_req < 0) first_req = c;
        hi++;
        if (hi == 2) begin
          q_d.push_back(int'(u_if.eject_denom));
          u_if.eject_ack = 1'b1;
          acked = 1'b1;
          hi = 0;
        end
      end else begin
        hi = 0;
      end
      if (extra_strobe && c == 10) begin
        u_if.change_in    = 12'h999;
        u_if.change_valid = 1'b1;
      end else begin
        u_if.change_valid = 1'b0;
      end
      if (u_if.done) begin
        n_done++;
        seen_done = 1'b1;
        check_val("busy_at_done", int'(u_if.busy), 0);
      end
    end
    check_val("done_seen", int'(seen_done), 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (u_if.done) n_done++;
    end
  endtask

  task automatic verify_payout(input string tag, input int exp_coins);
    int n;
    check_val({tag, "_n_items"}, q_d.size(), e_d.size());
    n = (q_d.size() < e_d.size()) ? q_d.size() : e_d.size();
    for (int i = 0; i < n; i++)
      check_val($sformatf("%s_denom%0d", tag, i), q_d[i], e_d[i]);
    n = (q_r.size() < e_r.size()) ? q_r.size() : e_r.size();
    check_val({tag, "_n_rem"}, q_r.size(), e_r.size());
    for (int i = 0; i < n; i++)
      check_val($sformatf("%s_rem%0d", tag, i), q_r[i], e_r[i]);
    check_val({tag, "_coin_count"}, int'(u_if.coin_count), exp_coins);
    check_val({tag, "_done_pulses"}, n_done, 1);
    check_val({tag, "_busy_after"}, int'(u_if.busy), 0);
    check_val({tag, "_first_req_cycle"}, first_req, 1);
  endtask

  task automatic wait_req(input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 30 && !ok; c++) begin
      @(negedge clk);
      if (u_if.eject_req) ok = 1'b1;
    end
    check_val(tag, int'(ok), 1);
  endtask

  initial begin
    int hi;
    bit any_req;
    u_if.change_in    = 12'h000;
    u_if.change_valid = 1'b0;
    u_if.eject_ack    = 1'b0;
    u_if.clear_fault  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_req",       int'(u_if.eject_req),  0);
    check_val("rst_busy",      int'(u_if.busy),       0);
    check_val("rst_remaining", int'(u_if.remaining),  0);
    check_val("rst_coins",     int'(u_if.coin_count), 0);
    check_val("rst_done",      int'(u_if.done),       0);
    check_val("rst_fault",     int'(u_if.fault),      0);
    rst = 1'b1;

    // 37 yuan: 20,10,5,1,1
    e_d = '{3, 2, 1, 0, 0};
    e_r = '{17, 7, 2, 1, 0};
    payout(12'h037, 1'b0);
    verify_payout("p37", 5);

    // Zero amount: done three edges after the strobe, nothing ejected
    any_req = 1'b0;
    @(negedge clk);
    u_if.change_in    = 12'h000;
    u_if.change_valid = 1'b1;
    @(negedge clk);
    u_if.change_valid = 1'b0;
    check_val("z_busy0", int'(u_if.busy), 1);
    check_val("z_done0", int'(u_if.done), 0);
    @(negedge clk);
    if (u_if.eject_req) any_req = 1'b1;
    check_val("z_done1", int'(u_if.done), 0);
    @(negedge clk);
    if (u_if.eject_req) any_req = 1'b1;
    check_val("z_done2", int'(u_if.done), 1);
    check_val("z_coins", int'(u_if.coin_count), 0);
    check_val("z_busy2", int'(u_if.busy), 0);
    @(negedge clk);
    check_val("z_done3", int'(u_if.done), 0);
    check_val("z_no_req", int'(any_req), 0);

    // Bad BCD digit
    any_req = 1'b0;
    u_if.change_in    = 12'h0A5;
    u_if.change_valid = 1'b1;
    @(negedge clk);
    u_if.change_valid = 1'b0;
    check_val("bcd_err_pulse", int'(u_if.bcd_err), 1);
    check_val("bcd_busy",      int'(u_if.busy),    0);
    @(negedge clk);
    check_val("bcd_err_clear", int'(u_if.bcd_err), 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (u_if.eject_req || u_if.busy) any_req = 1'b1;
    end
    check_val("bcd_no_activity", int'(any_req), 0);

    // Timeout: 15 yuan, never acked
    hi = 0;
    @(negedge clk);
    u_if.change_in    = 12'h015;
    u_if.change_valid = 1'b1;
    @(negedge clk);
    u_if.change_valid = 1'b0;
    for (int c = 0; c < 40 && !u_if.fault; c++) begin
      @(negedge clk);
      if (u_if.eject_req) hi++;
    end
    check_val("to_req_cycles", hi, 8);
    check_val("to_fault",      int'(u_if.fault),     1);
    check_val("to_remaining",  int'(u_if.remaining), 15);
    check_val("to_busy",       int'(u_if.busy),      1);
    check_val("to_req_low",    int'(u_if.eject_req), 0);
    u_if.clear_fault  = 1'b1;
    u_if.change_in    = 12'h037;
    u_if.change_valid = 1'b1;
    @(negedge clk);
    u_if.clear_fault  = 1'b0;
    u_if.change_valid = 1'b0;
    check_val("clr_fault",     int'(u_if.fault),     0);
    check_val("clr_remaining", int'(u_if.remaining), 0);
    check_val("clr_busy",      int'(u_if.busy),      0);
    repeat (3) @(negedge clk);
    check_val("clr_strobe_ignored", int'(u_if.busy), 0);

    // 37 again with a 999 strobe arriving mid-payout
    e_d = '{3, 2, 1, 0, 0};
    e_r = '{17, 7, 2, 1, 0};
    payout(12'h037, 1'b1);
    verify_payout("p37x", 5);

    // Reset while the second item is being requested
    @(negedge clk);
    u_if.change_in    = 12'h037;
    u_if.change_valid = 1'b1;
    @(negedge clk);
    u_if.change_valid = 1'b0;
    wait_req("mr_req1");
    u_if.eject_ack = 1'b1;
    @(negedge clk);
    u_if.eject_ack = 1'b0;
    wait_req("mr_req2");
    check_val("mr_pre_remaining", int'(u_if.remaining), 17);
    #2 rst = 1'b0;
    #1;
    check_val("mr_req",       int'(u_if.eject_req),   0);
    check_val("mr_busy",      int'(u_if.busy),        0);
    check_val("mr_remaining", int'(u_if.remaining),   0);
    check_val("mr_coins",     int'(u_if.coin_count),  0);
    check_val("mr_denom",     int'(u_if.eject_denom), 0);
    @(negedge clk);
    rst = 1'b1;

    e_d = '{1, 0};
    e_r = '{1, 0};
    payout(12'h006, 1'b0);
    verify_payout("p6", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
